// File: rtl/des_perm_pipe.sv
// Pipelined DES IP/FP bit-permutation engine, LANES x 64-bit blocks per beat, valid/ready on both sides.
// Optional completed-transfer counter on o_Count when DES_PERM_CNT_EN is defined.
module des_perm_pipe #(
    parameter int LANES      = 1,
    parameter int PIPE_DEPTH = 2
) (
    input  logic                  i_Clk,
    input  logic                  i_Rst,
    input  logic                  i_Valid,
    output logic                  o_Ready,
    input  logic                  i_Mode,
    input  logic [64*LANES-1:0]   i_Data,
    output logic                  o_Valid,
    input  logic                  i_Ready,
    output logic                  o_Mode,
    output logic [64*LANES-1:0]   o_Data
`ifdef DES_PERM_CNT_EN
    ,
    output logic [15:0]           o_Count
`endif
);

    localparam int W    = 64 * LANES;
    localparam int LAST = PIPE_DEPTH - 1;

    generate
        if (PIPE_DEPTH < 1 || PIPE_DEPTH > 4) begin : g_bad_depth
            $error("des_perm_pipe: PIPE_DEPTH must be in 1..4");
        end
        if (LANES < 1 || LANES > 8) begin : g_bad_lanes
            $error("des_perm_pipe: LANES must be in 1..8");
        end
    endgenerate

    logic [W-1:0] ip_w;
    logic [W-1:0] fp_w;
    logic [W-1:0] perm_w;

    // Pure wiring: FP is produced by swapping source and destination of every IP bit.
    genvar gi, gr, gj;
    generate
        for (gi = 0; gi < LANES; gi++) begin : g_lane
            for (gr = 0; gr < 8; gr++) begin : g_row
                localparam int SR = (gr < 4) ? (6 - 2 * gr) : (15 - 2 * gr);
                for (gj = 0; gj < 8; gj++) begin : g_col
                    localparam int DST = 64 * gi + 63 - (8 * gr + gj);
                    localparam int SRC = 64 * gi + SR + 8 * gj;
                    assign ip_w[DST] = i_Data[SRC];
                    assign fp_w[SRC] = i_Data[DST];
                end
            end
        end
    endgenerate

    assign perm_w = i_Mode ? fp_w : ip_w;

    logic [PIPE_DEPTH-1:0] vld_q, vld_d;
    logic [PIPE_DEPTH-1:0] mode_q, mode_d;
    logic [PIPE_DEPTH-1:0] load_w;
    logic [W-1:0]          data_q [PIPE_DEPTH];
    logic [W-1:0]          data_d [PIPE_DEPTH];

    // A stage may load when empty or when the stage after it is loading this cycle.
    always_comb begin : g_chain
        logic down_free;
        load_w    = '0;
        down_free = i_Ready;
        for (int k = LAST; k >= 0; k--) begin
            load_w[k] = !vld_q[k] || down_free;
            down_free = load_w[k];
        end
    end

    assign o_Ready = load_w[0];

    always_comb begin
        vld_d  = vld_q;
        mode_d = mode_q;
        data_d = data_q;
        if (load_w[0]) begin
            vld_d[0] = i_Valid;
            if (i_Valid) begin
                mode_d[0] = i_Mode;
                data_d[0] = perm_w;
            end
        end
        for (int k = 1; k < PIPE_DEPTH; k++) begin
            if (load_w[k]) begin
                vld_d[k] = vld_q[k-1];
                if (vld_q[k-1]) begin
                    mode_d[k] = mode_q[k-1];
                    data_d[k] = data_q[k-1];
                end
            end
        end
    end

    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            vld_q  <= '0;
            mode_q <= '0;
            for (int k = 0; k < PIPE_DEPTH; k++) begin
                data_q[k] <= '0;
            end
        end else begin
            vld_q  <= vld_d;
            mode_q <= mode_d;
            data_q <= data_d;
        end
    end

    assign o_Valid = vld_q[LAST];
    assign o_Mode  = mode_q[LAST];
    assign o_Data  = data_q[LAST];

`ifdef DES_PERM_CNT_EN
    logic [15:0] cnt_q, cnt_d;

    assign cnt_d = cnt_q + 16'd1;

    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            cnt_q <= '0;
        end else if (o_Valid && i_Ready) begin
            cnt_q <= cnt_d;
        end
    end

    assign o_Count = cnt_q;
`endif

endmodule

// File: tb/tb_des_perm_pipe.sv
// Bench for des_perm_pipe: three instances (1 lane/depth 2, 1 lane/depth 3, 4 lanes/depth 2)
// checked against a formula-level permutation model and queue scoreboards.
module tb_des_perm_pipe;

    logic clk, rst;

    logic        v1, or1, m1, ov1, r1, om1;
    logic [63:0] d1, od1;
    logic        v3, or3, m3, ov3, r3, om3;
    logic [63:0] d3, od3;
    logic         v4, or4, m4, ov4, r4, om4;
    logic [255:0] d4, od4;
`ifdef DES_PERM_CNT_EN
    logic [15:0] cnt1, cnt3, cnt4;
`endif

    int n_pass = 0;
    int n_total = 0;

    des_perm_pipe #(.LANES(1), .PIPE_DEPTH(2)) u1 (
        .i_Clk(clk), .i_Rst(rst), .i_Valid(v1), .o_Ready(or1), .i_Mode(m1), .i_Data(d1),
        .o_Valid(ov1), .i_Ready(r1), .o_Mode(om1), .o_Data(od1)
`ifdef DES_PERM_CNT_EN
        , .o_Count(cnt1)
`endif
    );

    des_perm_pipe #(.LANES(1), .PIPE_DEPTH(3)) u3 (
        .i_Clk(clk), .i_Rst(rst), .i_Valid(v3), .o_Ready(or3), .i_Mode(m3), .i_Data(d3),
        .o_Valid(ov3), .i_Ready(r3), .o_Mode(om3), .o_Data(od3)
`ifdef DES_PERM_CNT_EN
        , .o_Count(cnt3)
`endif
    );

    des_perm_pipe #(.LANES(4), .PIPE_DEPTH(2)) u4 (
        .i_Clk(clk), .i_Rst(rst), .i_Valid(v4), .o_Ready(or4), .i_Mode(m4), .i_Data(d4),
        .o_Valid(ov4), .i_Ready(r4), .o_Mode(om4), .o_Data(od4)
`ifdef DES_PERM_CNT_EN
        , .o_Count(cnt4)
`endif
    );

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    // IP straight from the rule out[63-(8r+j)] = in[s[r]+8j].
    function automatic logic [63:0] ip_ref(input logic [63:0] x);
        int s [8];
        logic [63:0] y;
        s = '{6, 4, 2, 0, 7, 5, 3, 1};
        y = '0;
        for (int r = 0; r < 8; r++)
            for (int j = 0; j < 8; j++)
                y[63 - (8 * r + j)] = x[s[r] + 8 * j];
        return y;
    endfunction

    // FP obtained by inverting the IP source table.
    function automatic logic [63:0] fp_ref(input logic [63:0] x);
        int s [8];
        int src [64];
        logic [63:0] y;
        s = '{6, 4, 2, 0, 7, 5, 3, 1};
        for (int r = 0; r < 8; r++)
            for (int j = 0; j < 8; j++)
                src[63 - (8 * r + j)] = s[r] + 8 * j;
        y = '0;
        for (int d = 0; d < 64; d++) y[src[d]] = x[d];
        return y;
    endfunction

    function automatic logic [63:0] perm_ref(input logic mode, input logic [63:0] x);
        return mode ? fp_ref(x) : ip_ref(x);
    endfunction

    function automatic logic [255:0] perm4_ref(input logic mode, input logic [255:0] x);
        logic [255:0] y;
        for (int l = 0; l < 4; l++) y[64*l +: 64] = perm_ref(mode, x[64*l +: 64]);
        return y;
    endfunction

    // Single beat on u1 with i_Ready held high; measures cycles until o_Valid.
    task automatic u1_beat(input logic mode, input logic [63:0] din, input logic [63:0] exp,
                           input string name, output logic [63:0] got);
        int lat;
        @(negedge clk);
        v1 = 1; m1 = mode; d1 = din; r1 = 1;
        #1 chk({name, " accept"}, or1, 1'b1);
        @(negedge clk);
        v1 = 0; m1 = 1'($urandom); d1 = {$urandom(), $urandom()};
        lat = 1;
        while (!ov1 && lat < 10) begin
            @(negedge clk);
            lat++;
        end
        chk({name, " latency"}, lat, 2);
        chk({name, " data"}, od1, exp);
        chk({name, " mode"}, om1, mode);
        got = od1;
    endtask

    typedef struct {
        logic        mode;
        logic [63:0] din;
        logic [63:0] exp;
    } vec_t;

    vec_t tbl [4];

    initial begin
        logic [63:0] x, y, y2;

        rst = 1;
        v1 = 0; m1 = 0; d1 = '0; r1 = 1;
        v3 = 0; m3 = 0; d3 = '0; r3 = 1;
        v4 = 0; m4 = 0; d4 = '0; r4 = 1;

        tbl[0] = '{1'b0, 64'h0000000000000001, 64'h0000008000000000};
        tbl[1] = '{1'b0, 64'h8000000000000000, 64'h0000000001000000};
        tbl[2] = '{1'b1, 64'h0000000001000000, 64'h8000000000000000};
        tbl[3] = '{1'b1, 64'h0000008000000000, 64'h0000000000000001};

        repeat (2) @(negedge clk);
        chk("reset o_Valid", ov1, 1'b0);
        chk("reset o_Data", od1, 64'h0);
        chk("reset o_Mode", om1, 1'b0);
        chk("reset o_Ready", or1, 1'b1);
        chk("reset o_Ready d3", or3, 1'b1);
        chk("reset o_Valid l4", ov4, 1'b0);
`ifdef DES_PERM_CNT_EN
        chk("reset o_Count", cnt1, 16'd0);
`endif
        rst = 0;

        for (int i = 0; i < 4; i++) begin
            u1_beat(tbl[i].mode, tbl[i].din, tbl[i].exp, $sformatf("vec%0d", i), y);
        end

        for (int i = 0; i < 6; i++) begin
            x = {$urandom(), $urandom()};
            u1_beat(1'b0, x, ip_ref(x), "roundtrip ip", y);
            u1_beat(1'b1, y, x, "roundtrip fp", y2);
        end

        // Back-to-back random stream, downstream always ready.
        begin
            logic [64:0] q [$];
            logic [64:0] e;
            int sent, got, first, last;
            sent = 0; got = 0; first = -1; last = -1;
            r1 = 1;
            for (int cyc = 0; cyc < 200 && (sent < 100 || got < 100); cyc++) begin
                @(negedge clk);
                if (ov1) begin
                    chk("b2b queue nonempty", q.size() != 0, 1'b1);
                    if (q.size() != 0) begin
                        e = q.pop_front();
                        chk("b2b data", od1, e[63:0]);
                        chk("b2b mode", om1, e[64]);
                    end
                    got++;
                    if (first < 0) first = cyc;
                    last = cyc;
                end
                if (sent < 100) begin
                    v1 = 1; m1 = 1'($urandom); d1 = {$urandom(), $urandom()};
                    #1 chk("b2b o_Ready", or1, 1'b1);
                    q.push_back({m1, perm_ref(m1, d1)});
                    sent++;
                end else begin
                    v1 = 0;
                end
            end
            chk("b2b count", got, 100);
            chk("b2b contiguous", last - first, 99);
        end

        // Random backpressure on the depth-3 instance.
        begin
            logic [64:0] q3 [$];
            logic [64:0] e;
            logic prev_stall, hm;
            logic [63:0] hd;
            int acc, emi;
            prev_stall = 0; hm = 0; hd = '0; acc = 0; emi = 0;
            for (int cyc = 0; cyc < 300; cyc++) begin
                @(negedge clk);
                if (prev_stall) begin
                    chk("stall valid held", ov3, 1'b1);
                    chk("stall data held", od3, hd);
                    chk("stall mode held", om3, hm);
                end
                r3 = 1'($urandom);
                v3 = ($urandom_range(9, 0) < 7);
                m3 = 1'($urandom);
                d3 = {$urandom(), $urandom()};
                #1;
                chk("stall o_Ready", or3, !(q3.size() == 3 && !r3));
                if (ov3 && r3) begin
                    chk("stall queue nonempty", q3.size() != 0, 1'b1);
                    if (q3.size() != 0) begin
                        e = q3.pop_front();
                        chk("stall data", od3, e[63:0]);
                        chk("stall mode", om3, e[64]);
                    end
                    emi++;
                end
                if (v3 && or3) begin
                    q3.push_back({m3, perm_ref(m3, d3)});
                    acc++;
                end
                prev_stall = ov3 && !r3;
                hd = od3;
                hm = om3;
            end
            v3 = 0; r3 = 1;
            for (int cyc = 0; cyc < 10; cyc++) begin
                @(negedge clk);
                #1;
                if (ov3) begin
                    chk("drain queue nonempty", q3.size() != 0, 1'b1);
                    if (q3.size() != 0) begin
                        e = q3.pop_front();
                        chk("drain data", od3, e[63:0]);
                        chk("drain mode", om3, e[64]);
                    end
                    emi++;
                end
            end
            chk("stall drained", q3.size(), 0);
            chk("stall in==out", emi, acc);
        end

        // Four lanes: fixed pattern first, then random beats.
        begin
            logic [255:0] din4 [11];
            logic         m4s [11];
            logic [256:0] q4 [$];
            logic [256:0] e;
            logic [255:0] exp0;
            int sent, got;
            din4[0] = {64'h8000000000000000, 64'h0000000000000001, 64'h0, 64'hFFFFFFFFFFFFFFFF};
            m4s[0] = 1'b0;
            exp0 = {64'h0000000001000000, 64'h0000008000000000, 64'h0, 64'hFFFFFFFFFFFFFFFF};
            for (int i = 1; i < 11; i++) begin
                din4[i] = {$urandom(), $urandom(), $urandom(), $urandom(),
                           $urandom(), $urandom(), $urandom(), $urandom()};
                m4s[i] = 1'($urandom);
            end
            sent = 0; got = 0; r4 = 1;
            for (int cyc = 0; cyc < 40 && got < 11; cyc++) begin
                @(negedge clk);
                if (ov4) begin
                    if (got == 0) chk("lanes fixed pattern", od4, exp0);
                    chk("lanes queue nonempty", q4.size() != 0, 1'b1);
                    if (q4.size() != 0) begin
                        e = q4.pop_front();
                        chk("lanes data", od4, e[255:0]);
                        chk("lanes mode", om4, e[256]);
                    end
                    got++;
                end
                if (sent < 11) begin
                    v4 = 1; m4 = m4s[sent]; d4 = din4[sent];
                    #1;
                    if (or4) begin
                        q4.push_back({m4, perm4_ref(m4, d4)});
                        sent++;
                    end
                end else begin
                    v4 = 0;
                end
            end
            v4 = 0;
            chk("lanes count", got, 11);
        end

        // Asynchronous reset with two beats in flight.
        @(negedge clk);
        r1 = 0; v1 = 1; m1 = 0; d1 = 64'h0123456789ABCDEF;
        @(negedge clk);
        m1 = 1; d1 = 64'hFEDCBA9876543210;
        @(negedge clk);
        v1 = 0;
        chk("pre-reset valid", ov1, 1'b1);
        chk("pre-reset data", od1, ip_ref(64'h0123456789ABCDEF));
        #2 rst = 1;
        #1;
        chk("async rst o_Valid", ov1, 1'b0);
        chk("async rst o_Data", od1, 64'h0);
        chk("async rst o_Mode", om1, 1'b0);
        chk("async rst o_Ready", or1, 1'b1);
`ifdef DES_PERM_CNT_EN
        chk("async rst o_Count", cnt1, 16'd0);
`endif
        @(negedge clk);
        rst = 0; r1 = 1;
        u1_beat(1'b0, 64'h0000000000000001, 64'h0000008000000000, "post-reset", y);

`ifdef DES_PERM_CNT_EN
        @(negedge clk);
        rst = 1;
        @(negedge clk);
        rst = 0;
        chk("count cleared", cnt1, 16'd0);
        v1 = 1; r1 = 1;
        repeat (65537) begin
            @(negedge clk);
            d1 = {$urandom(), $urandom()};
        end
        v1 = 0;
        repeat (5) @(negedge clk);
        chk("count wrap", cnt1, 16'd1);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/des_perm_pipe.md
Name: des_perm_pipe

Overview:
- Parametrised, pipelined DES bit-permutation engine with valid/ready handshake on both sides.
- Applies the DES Initial Permutation (IP) or its inverse, the Final Permutation (FP = IP^-1), selected per transfer, to LANES independent 64-bit blocks per beat.
- Sits between the block input buffer and the round datapath (IP mode), and between the round datapath and the output buffer (FP mode).
- Shared by encrypt and decrypt paths.

Parameters:
- LANES, 1: number of 64-bit blocks carried per beat; legal range 1..8.
- PIPE_DEPTH, 2: number of register stages; legal range 1..4. Elaboration error outside this range.

Ports:
- i_Clk  input  1  clock; all state updates on the rising edge.
- i_Rst  input  1  reset, asynchronous, active-high.
- i_Valid  input  1  input beat valid.
- o_Ready  output  1  block can accept an input beat this cycle.
- i_Mode  input  1  0 = IP, 1 = FP; sampled with the beat and applied to all lanes.
- i_Data  input  64*LANES  lane n occupies bits [64n+63:64n].
- o_Valid  output  1  output beat valid.
- i_Ready  input  1  downstream accepts the output beat.
- o_Mode  output  1  mode that travelled with the output beat.
- o_Data  output  64*LANES  permuted lanes, same lane packing as i_Data.

Behaviour:
- Permutation, per lane, with bit 0 as the LSB:
  - Let s = {6,4,2,0,7,5,3,1}, indexed by r = 0..7.
  - IP: out[63-(8r+j)] = in[s[r]+8j], for r, j in 0..7.
  - FP is the exact inverse: FP(IP(x)) = x for all x.
  - The permutation is combinational in front of stage 0. Stages 1..PIPE_DEPTH-1 only delay the beat.
- Pipeline:
  - Each stage k holds vld[k], mode[k] and data[k].
  - Stage k loads when it is empty or when its contents move downstream in the same cycle.
  - Last-stage advance condition: adv_last = o_Valid & i_Ready.
  - o_Ready = !vld[0] | adv[0]. It is derived combinationally from i_Ready through the chain; there is no skid buffer.
  - An input transfer occurs on i_Valid & o_Ready.
  - o_Valid = vld[PIPE_DEPTH-1]. o_Data and o_Mode are registers of the last stage.
- Latency and throughput:
  - PIPE_DEPTH cycles from input transfer to o_Valid when unstalled.
  - Throughput is 1 beat per cycle.
- Stall:
  - While o_Valid & !i_Ready, o_Data and o_Mode hold stable.
  - Upstream stages fill any bubbles. o_Ready drops only when every stage is valid and the output is stalled.
  - No beat is ever dropped or duplicated.
- Simultaneous events: a full pipeline with i_Ready = 1 and i_Valid = 1 accepts and emits in the same cycle.
- i_Mode and i_Data are ignored when i_Valid = 0. Their values do not affect state.
- Reset:
  - All vld cleared, data and mode registers cleared to 0, o_Valid = 0, o_Data = 0, o_Mode = 0.
  - o_Ready reads 1 while i_Rst is high and after release.
  - Reset mid-stream discards all in-flight beats. The first transfer after release starts a fresh latency count.

Optional Feature:
- Macro: DES_PERM_CNT_EN.
- With the macro defined:
  - Extra output port o_Count, output, 16 bits: number of completed output transfers (o_Valid & i_Ready).
  - Reset value 0; wraps from 16'hFFFF to 0; increments by exactly 1 per completed transfer.
- Without the macro: the port and the counter logic are absent. Data behaviour is identical in both builds.

Test Plan:
- Reset, then LANES=1, PIPE_DEPTH=2, i_Mode=0, i_Data=64'h0000000000000001 -> o_Data=64'h0000008000000000, o_Mode=0, o_Valid high exactly 2 cycles after acceptance.
- i_Mode=0, i_Data=64'h8000000000000000 -> 64'h0000000001000000. Then i_Mode=1 with that result -> 64'h8000000000000000. Then i_Mode=1, i_Data=64'h0000008000000000 -> 64'h0000000000000001.
- 100 back-to-back random beats with random i_Mode and i_Ready held at 1 -> o_Ready never drops, one output per cycle in order. Each output equals the reference permutation, and FP(IP(x)) = x over the stream.
- Random i_Ready toggling at 50% with PIPE_DEPTH=3 -> o_Data stable while stalled, o_Ready low only when all 3 stages are full. Beats are in order, with none lost or duplicated; scoreboard count matches.
- LANES=4, lanes loaded with 64'hFFFFFFFFFFFFFFFF, 0, 64'h1, 64'h8000000000000000, mode IP -> 64'hFFFFFFFFFFFFFFFF, 0, 64'h0000008000000000, 64'h0000000001000000 in the same lane positions.
- Assert i_Rst with 2 beats in flight -> o_Valid=0 and o_Data=0 immediately (asynchronous), o_Ready=1. With DES_PERM_CNT_EN, o_Count=0, and after 65537 completed transfers o_Count=1.
